l15_port_arb: RTL and testbench
===============================

# l15_port_arb

Parametrised multi-port front end for the L1.5 transducer interface. It merges NUM_PORTS independent core-side request ports onto the single transducer→L1.5 request channel with round-robin arbitration and per-port outstanding-request credits. It routes each L1.5 response back to its originating port by a port index carried in the upper threadid bits. Invalidation responses are broadcast to all ports and retired only once every port has acknowledged. It sits between the per-core transducers and the L1.5 wrapper in the tile.

## Interface
Parameters:
- NUM_PORTS, 2: request ports (2..4).
- PORT_IDX_W, 1: port index width, ≥ clog2(NUM_PORTS).
- TID_W, 1: per-port threadid width.
- MAX_OUTSTANDING, 2: outstanding non-broadcast requests allowed per port (1..7).
- INV_RTYPE, 4'd3: returntype value treated as broadcast invalidation.

Ports (P = NUM_PORTS, DT = TID_W+PORT_IDX_W):

Clock and reset:
- clk  in  1  — the single block clock.
- rst_n  in  1  — asynchronous, active-low reset.

Port-side requests:
- port_req_val  in  P  — per-port request valid; held until acked.
- port_req_rqtype  in  5P  — request type, packed, port 0 in LSBs.
- port_req_nc  in  P  — non-cacheable flag.
- port_req_size  in  3P  — request size.
- port_req_threadid  in  T·P  — per-port threadid (T = TID_W).
- port_req_address  in  40P  — request address.
- port_req_data  in  64P  — store data.
- port_req_ack  out  P  — one-cycle accept pulse.

Transducer→L1.5 request channel:
- transducer_l15_val  out  1  — request valid.
- transducer_l15_rqtype  out  5  — request type.
- transducer_l15_nc  out  1  — non-cacheable flag.
- transducer_l15_size  out  3  — request size.
- transducer_l15_threadid  out  DT  — {port index, port threadid}.
- transducer_l15_address  out  40  — request address.
- transducer_l15_data  out  64  — store data.
- l15_transducer_ack  in  1  — L1.5 accepts the request this cycle.

L1.5→transducer response channel:
- l15_transducer_val  in  1  — response valid; held until req_ack.
- l15_transducer_returntype  in  4  — response type.
- l15_transducer_threadid  in  DT  — returned threadid.
- l15_transducer_data  in  256  — data_3..data_0 concatenated.
- transducer_l15_req_ack  out  1  — response retire pulse.

Port-side responses:
- port_resp_val  out  P  — per-port response valid.
- port_resp_returntype  out  4  — shared across ports.
- port_resp_threadid  out  T  — threadid, port index stripped.
- port_resp_data  out  256  — shared response data.
- port_resp_ack  in  P  — per-port response accept.

## Operation
- Request FSM, states IDLE and GRANT:
  - IDLE: eligible = port_req_val & credit_ok, where credit_ok[p] = (cnt[p] < MAX_OUTSTANDING). Round-robin pick starting at rr_ptr. Register gnt (PORT_IDX_W bits) and go to GRANT. No eligible port: stay in IDLE.
  - GRANT: drive transducer_l15_* combinationally from port gnt's inputs, with transducer_l15_val = 1 and threadid = {gnt, port threadid}.
  - GRANT, on l15_transducer_ack: port_req_ack[gnt] = 1 in the same cycle, cnt[gnt] += 1, rr_ptr = gnt+1 mod P, return to IDLE.
  - The requester must not drop val or change fields while in GRANT.
- Response path, driven whenever l15_transducer_val = 1:
  - Broadcast = (returntype == INV_RTYPE).
  - target mask = all ones if broadcast, else one-hot(threadid[DT-1:TID_W]).
  - port_resp_val = target & ~done, where done is a P-bit register.
  - done accumulates port_resp_ack & port_resp_val.
  - Completion occurs when (done | (port_resp_ack & port_resp_val)) covers target. On completion: transducer_l15_req_ack = 1 for exactly that cycle, and done clears to 0.
  - A port index ≥ NUM_PORTS yields an empty target. Complete immediately (req_ack in the first cycle), with no port_resp_val.
- Credits:
  - Completion of a non-broadcast response decrements cnt of the owning port.
  - Broadcasts do not touch credits.
  - Increment and decrement of the same port in one cycle leave cnt unchanged.
  - A decrement at 0 saturates at 0.
- Request and response paths are independent; both may complete in the same cycle.

## Timing
- Reset values: state IDLE, rr_ptr 0, gnt 0, cnt all 0, done 0.
- Reset values of outputs: transducer_l15_val 0, port_req_ack 0, port_resp_val 0, transducer_l15_req_ack 0.
- Request latency: port_req_val high in cycle N with the block in IDLE gives transducer_l15_val in cycle N+1. With l15 acking immediately, port_req_ack pulses in N+1. Back-to-back grants happen every 2 cycles at best.
- Response latency: 0 cycles. port_resp_val follows l15_transducer_val combinationally.
- Reset asserted mid-operation: all state clears asynchronously. An in-flight grant is abandoned, and any outstanding L1.5 response is the system's responsibility.
- No combinational path from port_req_val to transducer_l15_val.

## Test plan
- Single request: port1 val, address 0x80_0000_1000, threadid 0. Expect transducer_l15_val next cycle with threadid {1,0}; l15 acks; port_req_ack[1] pulses once; cnt[1] = 1.
- Round-robin: ports 0 and 1 request continuously, l15 acks immediately. Expect grants 0,1,0,1, one grant every 2 cycles.
- Credit stall: MAX_OUTSTANDING = 2, port 0 issues 2 requests with no responses. The third is not granted while port 1 still proceeds. A response with threadid {0,x}, once acked, re-enables port 0 the next cycle.
- Routed response: l15_transducer_val with threadid {1,1}, data 0xDEADBEEF. Expect only port_resp_val[1] and port_resp_threadid 1. port_resp_ack[1] in cycle 3 gives transducer_l15_req_ack in cycle 3.
- Broadcast inval: returntype 3 with P = 2. Port 0 acks in cycle 1, port 1 in cycle 4. Expect port_resp_val[0] to drop after cycle 1, req_ack exactly in cycle 4, and credits unchanged.
- Reset mid-grant: assert rst_n low during GRANT. Outputs go to 0 at once; after release the first grant goes to port 0.

Source files
------------

// File: rtl/l15_port_arb.sv
// l15_port_arb -- multi-port front end for the L1.5 transducer interface.
//
// Merges NUM_PORTS core-side request ports onto the single transducer->L1.5
// request channel. Arbitration is round-robin, and each port has an
// outstanding-request credit limit. L1.5 responses are routed back to the
// port named by the upper threadid bits. Invalidations (INV_RTYPE) are
// broadcast to every port and retire only after all ports have accepted them.
//
// Ports (P = NUM_PORTS, DT = TID_W + PORT_IDX_W):
//   clk, rst_n                    clock, asynchronous active-low reset
//   port_req_*        [P]         packed per-port requests, port 0 in the LSBs
//   port_req_ack      [P]         one-cycle accept pulse to the granted port
//   transducer_l15_*              merged request toward L1.5, threadid = {port, tid}
//   l15_transducer_ack            L1.5 accepts the request in this cycle
//   l15_transducer_*              response from L1.5, held until req_ack
//   transducer_l15_req_ack        response retire pulse
//   port_resp_val     [P]         per-port response valid
//   port_resp_*                   shared response fields, port index stripped
//   port_resp_ack     [P]         per-port response accept
module l15_port_arb #(
  parameter int          NUM_PORTS       = 2,
  parameter int          PORT_IDX_W      = 1,
  parameter int          TID_W           = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [3:0]  INV_RTYPE       = 4'd3
) (
  input  logic                              clk,
  input  logic                              rst_n,

  input  logic [NUM_PORTS-1:0]              port_req_val,
  input  logic [5*NUM_PORTS-1:0]            port_req_rqtype,
  input  logic [NUM_PORTS-1:0]              port_req_nc,
  input  logic [3*NUM_PORTS-1:0]            port_req_size,
  input  logic [TID_W*NUM_PORTS-1:0]        port_req_threadid,
  input  logic [40*NUM_PORTS-1:0]           port_req_address,
  input  logic [64*NUM_PORTS-1:0]           port_req_data,
  output logic [NUM_PORTS-1:0]              port_req_ack,

  output logic                              transducer_l15_val,
  output logic [4:0]                        transducer_l15_rqtype,
  output logic                              transducer_l15_nc,
  output logic [2:0]                        transducer_l15_size,
  output logic [TID_W+PORT_IDX_W-1:0]       transducer_l15_threadid,
  output logic [39:0]                       transducer_l15_address,
  output logic [63:0]                       transducer_l15_data,
  input  logic                              l15_transducer_ack,

  input  logic                              l15_transducer_val,
  input  logic [3:0]                        l15_transducer_returntype,
  input  logic [TID_W+PORT_IDX_W-1:0]       l15_transducer_threadid,
  input  logic [255:0]                      l15_transducer_data,
  output logic                              transducer_l15_req_ack,

  output logic [NUM_PORTS-1:0]              port_resp_val,
  output logic [3:0]                        port_resp_returntype,
  output logic [TID_W-1:0]                  port_resp_threadid,
  output logic [255:0]                      port_resp_data,
  input  logic [NUM_PORTS-1:0]              port_resp_ack
);

  localparam int CNT_W = 3;
  localparam int DT    = TID_W + PORT_IDX_W;
  localparam logic [PORT_IDX_W-1:0] LAST_PORT = PORT_IDX_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // Saturating credit update: a simultaneous issue and retire cancel out,
  // and a retire with no credit in use is ignored.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic inc,
                                                 input logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + 1'b1;
    else if (dec && !inc && (cnt != '0))
      res = cnt - 1'b1;
    return res;
  endfunction

  state_t                  r_state;
  logic [PORT_IDX_W-1:0]   r_gnt;
  logic [PORT_IDX_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]        r_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0]    r_done;

  logic [NUM_PORTS-1:0]    w_eligible;
  logic                    w_pick_found;
  logic [PORT_IDX_W-1:0]   w_pick_idx;
  logic                    w_req_fire;
  logic [NUM_PORTS-1:0]    w_inc;
  logic [NUM_PORTS-1:0]    w_dec;
  logic [TID_W-1:0]        w_gnt_tid;

  logic                    w_bcast;
  logic [PORT_IDX_W-1:0]   w_rsp_idx;
  logic [NUM_PORTS-1:0]    w_target;
  logic [NUM_PORTS-1:0]    w_acked;
  logic                    w_complete;

  // ---------------------------------------------------------------- request
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      w_eligible[p] = port_req_val[p] && (r_cnt[p] < CNT_MAX);
  end

  // Round-robin pick: offset i from r_rr_ptr, lowest offset wins. Iterating
  // offsets from high to low lets the lowest eligible offset overwrite last.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_eligible[p] &&
            (r_rr_ptr == PORT_IDX_W'((p - i + NUM_PORTS) % NUM_PORTS))) begin
          w_pick_found = 1'b1;
          w_pick_idx   = PORT_IDX_W'(p);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_found) begin
            r_gnt   <= w_pick_idx;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (l15_transducer_ack) begin
            r_rr_ptr <= (r_gnt == LAST_PORT) ? '0 : r_gnt + 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign transducer_l15_val = (r_state == S_GRANT);
  assign w_req_fire         = transducer_l15_val && l15_transducer_ack;

  // Request fields follow the registered grant, so port_req_val never reaches
  // transducer_l15_val combinationally.
  always_comb begin
    transducer_l15_rqtype  = '0;
    transducer_l15_nc      = 1'b0;
    transducer_l15_size    = '0;
    transducer_l15_address = '0;
    transducer_l15_data    = '0;
    w_gnt_tid              = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_gnt == PORT_IDX_W'(p)) begin
        transducer_l15_rqtype  = port_req_rqtype[p*5 +: 5];
        transducer_l15_nc      = port_req_nc[p];
        transducer_l15_size    = port_req_size[p*3 +: 3];
        transducer_l15_address = port_req_address[p*40 +: 40];
        transducer_l15_data    = port_req_data[p*64 +: 64];
        w_gnt_tid              = port_req_threadid[p*TID_W +: TID_W];
      end
    end
  end

  assign transducer_l15_threadid = {r_gnt, w_gnt_tid};

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      port_req_ack[p] = w_req_fire && (r_gnt == PORT_IDX_W'(p));
  end

  // --------------------------------------------------------------- response
  assign w_bcast   = (l15_transducer_returntype == INV_RTYPE);
  assign w_rsp_idx = l15_transducer_threadid[DT-1:TID_W];

  // An out-of-range port index matches no bit, so the target is empty and
  // the response retires on its first cycle.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      w_target[p] = w_bcast || (w_rsp_idx == PORT_IDX_W'(p));
  end

  assign port_resp_val = l15_transducer_val ? (w_target & ~r_done) : '0;
  assign w_acked       = port_resp_ack & port_resp_val;
  assign w_complete    = l15_transducer_val &&
                         (((r_done | w_acked) & w_target) == w_target);

  assign transducer_l15_req_ack = w_complete;
  assign port_resp_returntype   = l15_transducer_returntype;
  assign port_resp_threadid     = l15_transducer_threadid[TID_W-1:0];
  assign port_resp_data         = l15_transducer_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_done <= '0;
    else if (w_complete)
      r_done <= '0;
    else
      r_done <= r_done | w_acked;
  end

  // ---------------------------------------------------------------- credits
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_inc[p] = w_req_fire && (r_gnt == PORT_IDX_W'(p));
      w_dec[p] = w_complete && !w_bcast && (w_rsp_idx == PORT_IDX_W'(p));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++)
        r_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        r_cnt[p] <= cnt_next(r_cnt[p], w_inc[p], w_dec[p]);
    end
  end

endmodule

// File: tb/tb_l15_port_arb.sv
// tb_l15_port_arb -- directed self-checking bench for l15_port_arb with the
// default configuration (2 ports, 1-bit port index, 1-bit threadid, 2 credits).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_l15_port_arb;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    port_req_val;
  logic [9:0]    port_req_rqtype;
  logic [1:0]    port_req_nc;
  logic [5:0]    port_req_size;
  logic [1:0]    port_req_threadid;
  logic [79:0]   port_req_address;
  logic [127:0]  port_req_data;
  logic [1:0]    port_req_ack;
  logic          transducer_l15_val;
  logic [4:0]    transducer_l15_rqtype;
  logic          transducer_l15_nc;
  logic [2:0]    transducer_l15_size;
  logic [1:0]    transducer_l15_threadid;
  logic [39:0]   transducer_l15_address;
  logic [63:0]   transducer_l15_data;
  logic          l15_transducer_ack;
  logic          l15_transducer_val;
  logic [3:0]    l15_transducer_returntype;
  logic [1:0]    l15_transducer_threadid;
  logic [255:0]  l15_transducer_data;
  logic          transducer_l15_req_ack;
  logic [1:0]    port_resp_val;
  logic [3:0]    port_resp_returntype;
  logic          port_resp_threadid;
  logic [255:0]  port_resp_data;
  logic [1:0]    port_resp_ack;

  int n_chk = 0;
  int n_err = 0;

  l15_port_arb dut (
    .clk(clk), .rst_n(rst_n),
    .port_req_val(port_req_val), .port_req_rqtype(port_req_rqtype),
    .port_req_nc(port_req_nc), .port_req_size(port_req_size),
    .port_req_threadid(port_req_threadid), .port_req_address(port_req_address),
    .port_req_data(port_req_data), .port_req_ack(port_req_ack),
    .transducer_l15_val(transducer_l15_val), .transducer_l15_rqtype(transducer_l15_rqtype),
    .transducer_l15_nc(transducer_l15_nc), .transducer_l15_size(transducer_l15_size),
    .transducer_l15_threadid(transducer_l15_threadid),
    .transducer_l15_address(transducer_l15_address),
    .transducer_l15_data(transducer_l15_data), .l15_transducer_ack(l15_transducer_ack),
    .l15_transducer_val(l15_transducer_val),
    .l15_transducer_returntype(l15_transducer_returntype),
    .l15_transducer_threadid(l15_transducer_threadid),
    .l15_transducer_data(l15_transducer_data),
    .transducer_l15_req_ack(transducer_l15_req_ack),
    .port_resp_val(port_resp_val), .port_resp_returntype(port_resp_returntype),
    .port_resp_threadid(port_resp_threadid), .port_resp_data(port_resp_data),
    .port_resp_ack(port_resp_ack)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    port_req_val = '0; port_req_rqtype = '0; port_req_nc = '0; port_req_size = '0;
    port_req_threadid = '0; port_req_address = '0; port_req_data = '0;
    l15_transducer_ack = 1'b0; l15_transducer_val = 1'b0;
    l15_transducer_returntype = '0; l15_transducer_threadid = '0;
    l15_transducer_data = '0; port_resp_ack = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    port_req_val = 2'b11;
    l15_transducer_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (transducer_l15_val !== 1'b0) begin n_err++; $display("FAIL rst_tval: got %b want 0", transducer_l15_val); end
    n_chk++; if (port_req_ack !== 2'b00) begin n_err++; $display("FAIL rst_req_ack: got %b want 00", port_req_ack); end
    n_chk++; if (port_resp_val !== 2'b00) begin n_err++; $display("FAIL rst_resp_val: got %b want 00", port_resp_val); end
    n_chk++; if (transducer_l15_req_ack !== 1'b0) begin n_err++; $display("FAIL rst_req_ack_l15: got %b want 0", transducer_l15_req_ack); end
    n_chk++; if (dut.r_cnt[0] !== 3'd0 || dut.r_cnt[1] !== 3'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", dut.r_cnt[0], dut.r_cnt[1]); end
    n_chk++; if (dut.r_done !== 2'b00) begin n_err++; $display("FAIL rst_done: got %b want 00", dut.r_done); end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    port_req_val = 2'b10;
    port_req_address[79:40] = 40'h80_0000_1000;
    port_req_rqtype[9:5] = 5'h01;
    port_req_size[5:3] = 3'd3;
    port_req_data[127:64] = 64'h0123_4567_89ab_cdef;
    port_req_threadid[1] = 1'b0;
    #1;
    n_chk++; if (transducer_l15_val !== 1'b0) begin n_err++; $display("FAIL single_comb_path: got %b want 0", transducer_l15_val); end
    @(negedge clk); #1;
    n_chk++; if (transducer_l15_val !== 1'b1) begin n_err++; $display("FAIL single_tval: got %b want 1", transducer_l15_val); end
    n_chk++; if (transducer_l15_threadid !== 2'b10) begin n_err++; $display("FAIL single_tid: got %b want 10", transducer_l15_threadid); end
    n_chk++; if (transducer_l15_address !== 40'h80_0000_1000) begin n_err++; $display("FAIL single_addr: got %h want 8000001000", transducer_l15_address); end
    n_chk++; if (transducer_l15_rqtype !== 5'h01 || transducer_l15_size !== 3'd3) begin n_err++; $display("FAIL single_fields: got %h/%h want 01/3", transducer_l15_rqtype, transducer_l15_size); end
    n_chk++; if (transducer_l15_data !== 64'h0123_4567_89ab_cdef) begin n_err++; $display("FAIL single_data: got %h want 0123456789abcdef", transducer_l15_data); end
    n_chk++; if (port_req_ack !== 2'b00) begin n_err++; $display("FAIL single_noack: got %b want 00", port_req_ack); end
    @(negedge clk);
    l15_transducer_ack = 1'b1;
    #1;
    n_chk++; if (port_req_ack !== 2'b10) begin n_err++; $display("FAIL single_ack: got %b want 10", port_req_ack); end
    @(negedge clk);
    port_req_val = 2'b00;
    l15_transducer_ack = 1'b0;
    #1;
    n_chk++; if (transducer_l15_val !== 1'b0 || port_req_ack !== 2'b00) begin n_err++; $display("FAIL single_after: got %b/%b want 0/00", transducer_l15_val, port_req_ack); end
    n_chk++; if (dut.r_cnt[1] !== 3'd1) begin n_err++; $display("FAIL single_cnt1: got %0d want 1", dut.r_cnt[1]); end
  endtask

  task automatic test_round_robin();
    logic       exp_val;
    logic [1:0] exp_ack;
    logic [1:0] exp_tid;
    do_reset();
    @(negedge clk);
    port_req_val = 2'b11;
    port_req_threadid = 2'b01;   // port 0 tid 1, port 1 tid 0
    l15_transducer_ack = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      exp_val = (k <= 8) && (k % 2 == 1);
      exp_ack = exp_val ? ((((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_tid = (exp_ack == 2'b01) ? 2'b01 : 2'b10;
      n_chk++; if (transducer_l15_val !== exp_val) begin n_err++; $display("FAIL rr_val c%0d: got %b want %b", k, transducer_l15_val, exp_val); end
      n_chk++; if (port_req_ack !== exp_ack) begin n_err++; $display("FAIL rr_ack c%0d: got %b want %b", k, port_req_ack, exp_ack); end
      if (exp_val) begin
        n_chk++; if (transducer_l15_threadid !== exp_tid) begin n_err++; $display("FAIL rr_tid c%0d: got %b want %b", k, transducer_l15_threadid, exp_tid); end
      end
    end
    port_req_val = 2'b00;
    l15_transducer_ack = 1'b0;
  endtask

  task automatic test_credit_stall();
    do_reset();
    @(negedge clk);
    port_req_val = 2'b01;
    l15_transducer_ack = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      n_chk++; if (transducer_l15_val !== (k == 1 || k == 3)) begin n_err++; $display("FAIL cs_p0 c%0d: got %b want %b", k, transducer_l15_val, (k == 1 || k == 3)); end
    end
    port_req_val = 2'b11;
    @(negedge clk); #1;
    n_chk++; if (transducer_l15_val !== 1'b1 || transducer_l15_threadid[1] !== 1'b1) begin n_err++; $display("FAIL cs_p1_grant: got %b/%b want 1/1", transducer_l15_val, transducer_l15_threadid[1]); end
    n_chk++; if (port_req_ack !== 2'b10) begin n_err++; $display("FAIL cs_p1_ack: got %b want 10", port_req_ack); end
    @(negedge clk);
    port_req_val = 2'b01;
    #1;
    n_chk++; if (transducer_l15_val !== 1'b0) begin n_err++; $display("FAIL cs_idle7: got %b want 0", transducer_l15_val); end
    @(negedge clk);
    l15_transducer_val = 1'b1;
    l15_transducer_threadid = 2'b01;
    l15_transducer_returntype = 4'd0;
    port_resp_ack = 2'b01;
    #1;
    n_chk++; if (transducer_l15_val !== 1'b0) begin n_err++; $display("FAIL cs_stall8: got %b want 0", transducer_l15_val); end
    n_chk++; if (port_resp_val !== 2'b01 || transducer_l15_req_ack !== 1'b1) begin n_err++; $display("FAIL cs_resp: got %b/%b want 01/1", port_resp_val, transducer_l15_req_ack); end
    @(negedge clk);
    l15_transducer_val = 1'b0;
    port_resp_ack = 2'b00;
    #1;
    n_chk++; if (transducer_l15_val !== 1'b0) begin n_err++; $display("FAIL cs_idle9: got %b want 0", transducer_l15_val); end
    @(negedge clk); #1;
    n_chk++; if (transducer_l15_val !== 1'b1 || transducer_l15_threadid[1] !== 1'b0 || port_req_ack !== 2'b01) begin n_err++; $display("FAIL cs_reenable: got %b/%b/%b want 1/0/01", transducer_l15_val, transducer_l15_threadid[1], port_req_ack); end
    @(negedge clk);
    port_req_val = 2'b00;
    l15_transducer_ack = 1'b0;
  endtask

  task automatic test_routed();
    do_reset();
    @(negedge clk);
    l15_transducer_val = 1'b1;
    l15_transducer_returntype = 4'd0;
    l15_transducer_threadid = 2'b11;
    l15_transducer_data = 256'hDEADBEEF;
    #1;
    n_chk++; if (port_resp_val !== 2'b10) begin n_err++; $display("FAIL rt_val: got %b want 10", port_resp_val); end
    n_chk++; if (port_resp_threadid !== 1'b1) begin n_err++; $display("FAIL rt_tid: got %b want 1", port_resp_threadid); end
    n_chk++; if (port_resp_data !== 256'hDEADBEEF || port_resp_returntype !== 4'd0) begin n_err++; $display("FAIL rt_data: got %h/%h want deadbeef/0", port_resp_data[31:0], port_resp_returntype); end
    n_chk++; if (transducer_l15_req_ack !== 1'b0) begin n_err++; $display("FAIL rt_early_ack c1: got %b want 0", transducer_l15_req_ack); end
    @(negedge clk); #1;
    n_chk++; if (port_resp_val !== 2'b10 || transducer_l15_req_ack !== 1'b0) begin n_err++; $display("FAIL rt_hold c2: got %b/%b want 10/0", port_resp_val, transducer_l15_req_ack); end
    @(negedge clk);
    port_resp_ack = 2'b10;
    #1;
    n_chk++; if (transducer_l15_req_ack !== 1'b1) begin n_err++; $display("FAIL rt_req_ack c3: got %b want 1", transducer_l15_req_ack); end
    @(negedge clk);
    l15_transducer_val = 1'b0;
    port_resp_ack = 2'b00;
    #1;
    n_chk++; if (transducer_l15_req_ack !== 1'b0 || port_resp_val !== 2'b00) begin n_err++; $display("FAIL rt_end: got %b/%b want 0/00", transducer_l15_req_ack, port_resp_val); end
    n_chk++; if (dut.r_cnt[1] !== 3'd0) begin n_err++; $display("FAIL rt_cnt_sat: got %0d want 0", dut.r_cnt[1]); end
  endtask

  task automatic test_broadcast();
    do_reset();
    @(negedge clk);
    port_req_val = 2'b01;
    l15_transducer_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    port_req_val = 2'b00;
    l15_transducer_ack = 1'b0;
    @(negedge clk);
    l15_transducer_val = 1'b1;
    l15_transducer_returntype = 4'd3;
    l15_transducer_threadid = 2'b00;
    port_resp_ack = 2'b01;
    #1;
    n_chk++; if (port_resp_val !== 2'b11 || transducer_l15_req_ack !== 1'b0) begin n_err++; $display("FAIL bc_c1: got %b/%b want 11/0", port_resp_val, transducer_l15_req_ack); end
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      port_resp_ack = 2'b00;
      #1;
      n_chk++; if (port_resp_val !== 2'b10 || transducer_l15_req_ack !== 1'b0) begin n_err++; $display("FAIL bc_c%0d: got %b/%b want 10/0", k, port_resp_val, transducer_l15_req_ack); end
    end
    @(negedge clk);
    port_resp_ack = 2'b10;
    #1;
    n_chk++; if (port_resp_val !== 2'b10 || transducer_l15_req_ack !== 1'b1) begin n_err++; $display("FAIL bc_c4: got %b/%b want 10/1", port_resp_val, transducer_l15_req_ack); end
    @(negedge clk);
    l15_transducer_returntype = 4'd0;
    port_resp_ack = 2'b00;
    #1;
    n_chk++; if (port_resp_val !== 2'b01 || transducer_l15_req_ack !== 1'b0) begin n_err++; $display("FAIL bc_done_clr: got %b/%b want 01/0", port_resp_val, transducer_l15_req_ack); end
    n_chk++; if (dut.r_cnt[0] !== 3'd1 || dut.r_cnt[1] !== 3'd0) begin n_err++; $display("FAIL bc_credits: got %0d/%0d want 1/0", dut.r_cnt[0], dut.r_cnt[1]); end
    @(negedge clk);
    port_resp_ack = 2'b01;
    #1;
    n_chk++; if (transducer_l15_req_ack !== 1'b1) begin n_err++; $display("FAIL bc_routed_ack: got %b want 1", transducer_l15_req_ack); end
    @(negedge clk);
    l15_transducer_val = 1'b0;
    port_resp_ack = 2'b00;
    #1;
    n_chk++; if (dut.r_cnt[0] !== 3'd0) begin n_err++; $display("FAIL bc_cnt_dec: got %0d want 0", dut.r_cnt[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    port_req_val = 2'b01;
    l15_transducer_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    l15_transducer_ack = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (transducer_l15_val !== 1'b1 || port_req_ack !== 2'b00) begin n_err++; $display("FAIL b2b_grant: got %b/%b want 1/00", transducer_l15_val, port_req_ack); end
    @(negedge clk);
    l15_transducer_ack = 1'b1;
    l15_transducer_val = 1'b1;
    l15_transducer_returntype = 4'd0;
    l15_transducer_threadid = 2'b00;
    port_resp_ack = 2'b01;
    #1;
    n_chk++; if (port_req_ack !== 2'b01 || transducer_l15_req_ack !== 1'b1) begin n_err++; $display("FAIL b2b_both: got %b/%b want 01/1", port_req_ack, transducer_l15_req_ack); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_chk++; if (dut.r_cnt[0] !== 3'd1) begin n_err++; $display("FAIL b2b_cnt: got %0d want 1", dut.r_cnt[0]); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    @(negedge clk);
    port_req_val = 2'b01;
    l15_transducer_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    port_req_val = 2'b10;
    l15_transducer_ack = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (transducer_l15_val !== 1'b1 || transducer_l15_threadid[1] !== 1'b1) begin n_err++; $display("FAIL rmg_grant1: got %b/%b want 1/1", transducer_l15_val, transducer_l15_threadid[1]); end
    l15_transducer_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (transducer_l15_val !== 1'b0 || port_req_ack !== 2'b00) begin n_err++; $display("FAIL rmg_async: got %b/%b want 0/00", transducer_l15_val, port_req_ack); end
    n_chk++; if (dut.r_cnt[0] !== 3'd0) begin n_err++; $display("FAIL rmg_cnt: got %0d want 0", dut.r_cnt[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    port_req_val = 2'b11;
    l15_transducer_ack = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (transducer_l15_val !== 1'b1 || transducer_l15_threadid[1] !== 1'b0) begin n_err++; $display("FAIL rmg_first_p0: got %b/%b want 1/0", transducer_l15_val, transducer_l15_threadid[1]); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_routed();
    test_broadcast();
    test_back_to_back();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
